// File: rtl/pipe_pattern_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pattern_pkg
// Description : Shared pattern-mode encodings, LFSR taps and seed handling
//               for the pipe pattern engine.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pattern_pkg;

    localparam logic [1:0]  MODE_LFSR     = 2'b00;
    localparam logic [1:0]  MODE_CNT      = 2'b01;
    localparam logic [1:0]  MODE_WALK     = 2'b10;

    localparam int          LFSR_TAP_A    = 31;
    localparam int          LFSR_TAP_B    = 21;
    localparam int          LFSR_TAP_C    = 1;
    localparam int          LFSR_TAP_D    = 0;

    localparam logic [31:0] DEFAULT_STATE = 32'h0000_0001;

    // An all-zero state locks up both the LFSR and the walking-one rotator.
    function automatic logic [31:0] seed_fixup(input logic [31:0] seed, input logic [1:0] mode);
        if ((seed == 32'd0) && (mode != MODE_CNT)) begin
            return DEFAULT_STATE;
        end
        return seed;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : pattern_gen
// Description : 32-bit pattern state with load/advance; used as both the
//               checker and the generator of the pipe pattern engine.
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_gen
    import pipe_pattern_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [31:0]       i_seed,
    input  logic              i_advance,
    input  logic [1:0]        i_mode,
    output logic [DATA_W-1:0] o_word
);

    logic [31:0] r_state;
    logic [31:0] w_next;
    logic        w_feedback;

    assign w_feedback = r_state[LFSR_TAP_A] ^ r_state[LFSR_TAP_B]
                      ^ r_state[LFSR_TAP_C] ^ r_state[LFSR_TAP_D];

    always_comb begin
        w_next = {r_state[30:0], w_feedback};
        case (i_mode)
            MODE_LFSR: w_next = {r_state[30:0], w_feedback};
            MODE_CNT:  w_next = r_state + 32'd1;
            MODE_WALK: w_next = {r_state[30:0], r_state[31]};
            default:   w_next = {r_state[30:0], w_feedback};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= DEFAULT_STATE;
        end else if (i_load) begin
            r_state <= i_seed;
        end else if (i_advance) begin
            r_state <= w_next;
        end
    end

    assign o_word = r_state[DATA_W-1:0];

endmodule
`default_nettype wire

// File: rtl/pipe_pattern_engine.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pattern_engine
// Description : Pseudorandom pipe source/sink with throttling, saturating
//               error count and optional first-error capture
//               (enabled by defining PIPE_PATTERN_ERRLOG_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_pattern_engine
    import pipe_pattern_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ERR_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic [1:0]        mode,
    input  logic [31:0]       seed,
    input  logic [7:0]        throttle,
    input  logic              pipe_in_write,
    input  logic [DATA_W-1:0] pipe_in_data,
    output logic              pipe_in_ready,
    input  logic              pipe_out_read,
    output logic [DATA_W-1:0] pipe_out_data,
    output logic              pipe_out_valid,
    output logic [ERR_W-1:0]  error_count,
    output logic [31:0]       words_in,
    output logic [31:0]       words_out,
    output logic              protocol_err,
    output logic [31:0]       first_err_index,
    output logic [DATA_W-1:0] first_err_expected,
    output logic [DATA_W-1:0] first_err_received
);

    logic [7:0]        r_rot;
    logic [ERR_W-1:0]  r_err_count;
    logic [31:0]       r_words_in;
    logic [31:0]       r_words_out;
    logic              r_proto_err;
    logic [31:0]       w_load_seed;
    logic [DATA_W-1:0] w_exp_word;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_mismatch;
    logic              w_proto_viol;

    // Ready/valid gate on restart so a coincident strobe is neither accepted nor flagged.
    assign pipe_in_ready  = r_rot[0] & ~restart;
    assign pipe_out_valid = r_rot[4] & ~restart;
    assign w_wr_acc       = pipe_in_write & pipe_in_ready;
    assign w_rd_acc       = pipe_out_read & pipe_out_valid;
    assign w_mismatch     = w_wr_acc & (pipe_in_data != w_exp_word);
    assign w_proto_viol   = ~restart & ((pipe_in_write & ~r_rot[0]) | (pipe_out_read & ~r_rot[4]));
    assign w_load_seed    = seed_fixup(seed, mode);

    pattern_gen #(.DATA_W(DATA_W)) u_checker (
        .clk       (clk),
        .rst       (reset),
        .i_load    (restart),
        .i_seed    (w_load_seed),
        .i_advance (w_wr_acc),
        .i_mode    (mode),
        .o_word    (w_exp_word)
    );

    pattern_gen #(.DATA_W(DATA_W)) u_generator (
        .clk       (clk),
        .rst       (reset),
        .i_load    (restart),
        .i_seed    (w_load_seed),
        .i_advance (w_rd_acc),
        .i_mode    (mode),
        .o_word    (pipe_out_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rot <= 8'hFF;
        end else if (restart) begin
            r_rot <= throttle;
        end else begin
            r_rot <= {r_rot[0], r_rot[7:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_count <= '0;
            r_words_in  <= '0;
            r_words_out <= '0;
        end else if (restart) begin
            r_err_count <= '0;
            r_words_in  <= '0;
            r_words_out <= '0;
        end else begin
            if (w_mismatch && (r_err_count != {ERR_W{1'b1}})) begin
                r_err_count <= r_err_count + 1'b1;
            end
            if (w_wr_acc) begin
                r_words_in <= r_words_in + 32'd1;
            end
            if (w_rd_acc) begin
                r_words_out <= r_words_out + 32'd1;
            end
        end
    end

    // Sticky until reset: a protocol violation is a host bug worth keeping visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_proto_err <= 1'b0;
        end else if (w_proto_viol) begin
            r_proto_err <= 1'b1;
        end
    end

    assign error_count  = r_err_count;
    assign words_in     = r_words_in;
    assign words_out    = r_words_out;
    assign protocol_err = r_proto_err;

`ifdef PIPE_PATTERN_ERRLOG_EN
    logic              r_err_logged;
    logic [31:0]       r_first_idx;
    logic [DATA_W-1:0] r_first_exp;
    logic [DATA_W-1:0] r_first_rcv;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_logged <= 1'b0;
            r_first_idx  <= '0;
            r_first_exp  <= '0;
            r_first_rcv  <= '0;
        end else if (restart) begin
            r_err_logged <= 1'b0;
            r_first_idx  <= '0;
            r_first_exp  <= '0;
            r_first_rcv  <= '0;
        end else if (w_mismatch && !r_err_logged) begin
            r_err_logged <= 1'b1;
            r_first_idx  <= r_words_in;
            r_first_exp  <= w_exp_word;
            r_first_rcv  <= pipe_in_data;
        end
    end

    assign first_err_index    = r_first_idx;
    assign first_err_expected = r_first_exp;
    assign first_err_received = r_first_rcv;
`else
    assign first_err_index    = '0;
    assign first_err_expected = '0;
    assign first_err_received = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_pattern_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_pattern_engine
// Description : Self-checking bench for pipe_pattern_engine (DATA_W 32, ERR_W 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_pattern_engine;

    localparam int DATA_W = 32;
    localparam int ERR_W  = 4;
    localparam logic [31:0] CORRUPT = 32'hA5A5_0000;

    logic              clk;
    logic              reset;
    logic              restart;
    logic [1:0]        mode;
    logic [31:0]       seed;
    logic [7:0]        throttle;
    logic              pipe_in_write;
    logic [DATA_W-1:0] pipe_in_data;
    logic              pipe_in_ready;
    logic              pipe_out_read;
    logic [DATA_W-1:0] pipe_out_data;
    logic              pipe_out_valid;
    logic [ERR_W-1:0]  error_count;
    logic [31:0]       words_in;
    logic [31:0]       words_out;
    logic              protocol_err;
    logic [31:0]       first_err_index;
    logic [DATA_W-1:0] first_err_expected;
    logic [DATA_W-1:0] first_err_received;

    pipe_pattern_engine #(.DATA_W(DATA_W), .ERR_W(ERR_W)) dut (
        .clk                (clk),
        .reset              (reset),
        .restart            (restart),
        .mode               (mode),
        .seed               (seed),
        .throttle           (throttle),
        .pipe_in_write      (pipe_in_write),
        .pipe_in_data       (pipe_in_data),
        .pipe_in_ready      (pipe_in_ready),
        .pipe_out_read      (pipe_out_read),
        .pipe_out_data      (pipe_out_data),
        .pipe_out_valid     (pipe_out_valid),
        .error_count        (error_count),
        .words_in           (words_in),
        .words_out          (words_out),
        .protocol_err       (protocol_err),
        .first_err_index    (first_err_index),
        .first_err_expected (first_err_expected),
        .first_err_received (first_err_received)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec  = 0;
    int          n_fail = 0;
    logic [31:0] sb_q[$];
    logic [31:0] ref_s;
    logic [1:0]  ref_m;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] seed;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] w3;
    } rd_vec_t;

    rd_vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_next(input logic [31:0] s, input logic [1:0] m);
        case (m)
            2'b01:   return s + 32'd1;
            2'b10:   return {s[30:0], s[31]};
            default: return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
        endcase
    endfunction

    task automatic do_restart(input logic [1:0] m, input logic [31:0] s, input logic [7:0] t);
        @(negedge clk);
        restart = 1'b1; mode = m; seed = s; throttle = t;
        pipe_in_write = 1'b0; pipe_out_read = 1'b0;
        @(negedge clk);
        restart = 1'b0;
        ref_m = m;
        ref_s = ((s == 32'd0) && (m != 2'b01)) ? 32'd1 : s;
    endtask

    // Expected words come off the scoreboard as each read is accepted.
    task automatic do_reads(input int n);
        logic [31:0] exp;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pipe_out_read = 1'b1;
            #1;
            if (!pipe_out_valid) begin
                check("rd_valid", {31'd0, pipe_out_valid}, 32'd1);
            end else if (sb_q.size() == 0) begin
                check("rd_sb_empty", 32'd0, 32'd1);
            end else begin
                exp = sb_q.pop_front();
                check("rd_data", pipe_out_data, exp);
            end
        end
        @(negedge clk);
        pipe_out_read = 1'b0;
        #1;
    endtask

    task automatic do_writes(input int n, input int bad_a, input int bad_b, input bit all_bad);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pipe_in_write = 1'b1;
            pipe_in_data  = ref_s[DATA_W-1:0]
                          ^ ((all_bad || i == bad_a || i == bad_b) ? CORRUPT : 32'd0);
            ref_s = ref_next(ref_s, ref_m);
        end
        @(negedge clk);
        pipe_in_write = 1'b0;
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{mode: 2'b01, seed: 32'hFFFF_FFFE, w0: 32'hFFFF_FFFE, w1: 32'hFFFF_FFFF, w2: 32'h0000_0000, w3: 32'h0000_0001};
        tbl[1] = '{mode: 2'b10, seed: 32'h0000_0000, w0: 32'h0000_0001, w1: 32'h0000_0002, w2: 32'h0000_0004, w3: 32'h0000_0008};
        tbl[2] = '{mode: 2'b10, seed: 32'h8000_0000, w0: 32'h8000_0000, w1: 32'h0000_0001, w2: 32'h0000_0002, w3: 32'h0000_0004};
        tbl[3] = '{mode: 2'b00, seed: 32'h0000_0000, w0: 32'h0000_0001, w1: 32'h0000_0003, w2: 32'h0000_0006, w3: 32'h0000_000D};
        tbl[4] = '{mode: 2'b11, seed: 32'h0000_0000, w0: 32'h0000_0001, w1: 32'h0000_0003, w2: 32'h0000_0006, w3: 32'h0000_000D};
        tbl[5] = '{mode: 2'b01, seed: 32'h0000_0000, w0: 32'h0000_0000, w1: 32'h0000_0001, w2: 32'h0000_0002, w3: 32'h0000_0003};
        tbl[6] = '{mode: 2'b00, seed: 32'h8000_0000, w0: 32'h8000_0000, w1: 32'h0000_0001, w2: 32'h0000_0003, w3: 32'h0000_0006};

        reset = 1'b1; restart = 1'b0; mode = 2'b00; seed = 32'd0; throttle = 8'hFF;
        pipe_in_write = 1'b0; pipe_in_data = '0; pipe_out_read = 1'b0;
        ref_s = 32'd1; ref_m = 2'b00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_out_data", pipe_out_data, 32'd1);
        check("rst_valid", {31'd0, pipe_out_valid}, 32'd1);
        check("rst_ready", {31'd0, pipe_in_ready}, 32'd1);
        check("rst_err_count", {28'd0, error_count}, 32'd0);
        check("rst_words_in", words_in, 32'd0);
        check("rst_words_out", words_out, 32'd0);
        check("rst_proto", {31'd0, protocol_err}, 32'd0);
        check("rst_first_idx", first_err_index, 32'd0);
        check("rst_first_exp", first_err_expected, 32'd0);

        // Restart coincident with both strobes: dropped, no protocol error.
        @(negedge clk);
        restart = 1'b1; pipe_in_write = 1'b1; pipe_out_read = 1'b1; pipe_in_data = 32'd1;
        #1;
        check("rs_ready_low", {31'd0, pipe_in_ready}, 32'd0);
        check("rs_valid_low", {31'd0, pipe_out_valid}, 32'd0);
        @(negedge clk);
        restart = 1'b0; pipe_in_write = 1'b0; pipe_out_read = 1'b0;
        #1;
        check("rs_proto", {31'd0, protocol_err}, 32'd0);
        check("rs_words_in", words_in, 32'd0);

        // 1024 correct LFSR words from seed 0 (fixed up to 1).
        do_restart(2'b00, 32'd0, 8'hFF);
        do_writes(1024, -1, -1, 1'b0);
        check("lfsr_err_count", {28'd0, error_count}, 32'd0);
        check("lfsr_words_in", words_in, 32'd1024);
        check("lfsr_proto", {31'd0, protocol_err}, 32'd0);

        // Read-side pattern table.
        for (int v = 0; v < 7; v++) begin
            do_restart(tbl[v].mode, tbl[v].seed, 8'hFF);
            sb_q.push_back(tbl[v].w0);
            sb_q.push_back(tbl[v].w1);
            sb_q.push_back(tbl[v].w2);
            sb_q.push_back(tbl[v].w3);
            do_reads(4);
            check("tbl_words_out", words_out, 32'd4);
            check("tbl_sb_drained", sb_q.size(), 32'd0);
        end

        // Counter mode with words 10 and 57 corrupted.
        do_restart(2'b01, 32'd0, 8'hFF);
        do_writes(100, 10, 57, 1'b0);
        check("cnt_err_count", {28'd0, error_count}, 32'd2);
        check("cnt_words_in", words_in, 32'd100);
`ifdef PIPE_PATTERN_ERRLOG_EN
        check("cnt_first_idx", first_err_index, 32'd10);
        check("cnt_first_exp", first_err_expected, 32'd10);
        check("cnt_first_rcv", first_err_received, 32'd10 ^ CORRUPT);
`else
        check("cnt_first_idx", first_err_index, 32'd0);
        check("cnt_first_exp", first_err_expected, 32'd0);
        check("cnt_first_rcv", first_err_received, 32'd0);
`endif

        // Saturation of the 4-bit error counter.
        do_restart(2'b01, 32'd0, 8'hFF);
        do_writes(14, -1, -1, 1'b1);
        check("sat_err_14", {28'd0, error_count}, 32'd14);
        do_writes(6, -1, -1, 1'b1);
        check("sat_err_max", {28'd0, error_count}, 32'hF);
        check("sat_words_in", words_in, 32'd20);
`ifdef PIPE_PATTERN_ERRLOG_EN
        check("sat_first_idx", first_err_index, 32'd0);
        check("sat_first_rcv", first_err_received, CORRUPT);
`else
        check("sat_first_rcv", first_err_received, 32'd0);
`endif

        // Throttle 8'h0F: ready high 4 of 8 cycles, valid on the other 4.
        do_restart(2'b00, 32'd0, 8'h0F);
        for (int i = 0; i < 8; i++) begin
            #1;
            check("thr_ready", {31'd0, pipe_in_ready}, (i < 4) ? 32'd1 : 32'd0);
            check("thr_valid", {31'd0, pipe_out_valid}, (i < 4) ? 32'd0 : 32'd1);
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check("thr_proto_before", {31'd0, protocol_err}, 32'd0);
        pipe_in_write = 1'b1;
        pipe_in_data  = 32'd1;
        #1;
        check("thr_ready_low", {31'd0, pipe_in_ready}, 32'd0);
        @(negedge clk);
        pipe_in_write = 1'b0;
        #1;
        check("thr_words_in", words_in, 32'd0);
        check("thr_proto", {31'd0, protocol_err}, 32'd1);
        check("thr_err_count", {28'd0, error_count}, 32'd0);

        // Asynchronous reset mid-burst, between clock edges.
        do_restart(2'b01, 32'h1234_0000, 8'hFF);
        @(negedge clk);
        pipe_out_read = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_out_data", pipe_out_data, 32'd1);
        check("arst_words_out", words_out, 32'd0);
        check("arst_proto", {31'd0, protocol_err}, 32'd0);
        check("arst_valid", {31'd0, pipe_out_valid}, 32'd1);
        pipe_out_read = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        do_restart(2'b10, 32'd0, 8'hFF);
        sb_q.push_back(32'd1);
        sb_q.push_back(32'd2);
        sb_q.push_back(32'd4);
        sb_q.push_back(32'd8);
        do_reads(4);
        check("arst_walk_words_out", words_out, 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_pattern_engine.md
# pipe_pattern_engine

Parametrised pseudorandom pipe source/sink for host-transfer integrity and throughput testing, the next generation of the 16-bit pipe checkers. It sits between a BTPipeIn/BTPipeOut endpoint pair and the wire endpoints, on the host-interface clock. It adds:
- configurable data width and pattern mode
- programmable seed
- ready/valid throttling
- saturating error and word counters
- optional first-error capture

## Interface
- DATA_W, 16: pipe word width; legal values 16 or 32.
- ERR_W, 16: error counter width.
- clk  in  1  host-interface clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- restart  in  1  synchronous; reloads seed and throttle, clears counters.
- mode  in  2  pattern select: 00 LFSR, 01 counter, 10 walking-one, 11 treated as LFSR.
- seed  in  32  initial pattern state, sampled on restart.
- throttle  in  8  ready/valid duty pattern, sampled on restart.
- pipe_in_write  in  1  host word strobe.
- pipe_in_data  in  DATA_W  host word.
- pipe_in_ready  out  1  sink may accept.
- pipe_out_read  in  1  host read strobe.
- pipe_out_data  out  DATA_W  current source word.
- pipe_out_valid  out  1  source word available.
- error_count  out  ERR_W  saturating mismatch count.
- words_in  out  32  accepted write count, wraps.
- words_out  out  32  accepted read count, wraps.
- protocol_err  out  1  sticky; set by a write without ready or a read without valid.
- first_err_index  out  32  words_in value at the first mismatch.
- first_err_expected  out  DATA_W  expected word at the first mismatch.
- first_err_received  out  DATA_W  received word at the first mismatch.

## Operation
- Two independent 32-bit pattern states: `exp_state` (checker) and `gen_state` (generator). Word = state[DATA_W-1:0].
- Next-state by mode:
  - LFSR: {s[30:0], s[31]^s[21]^s[1]^s[0]}.
  - Counter: s+1, mod 2^32.
  - Walking-one: rotate left 1.
- Mode is sampled combinationally each advance; software changes it only together with restart.
- Restart: both states load seed. A seed of 0 loads 32'h0000_0001 in LFSR and walking-one modes (lockup avoidance). Counter mode loads 0 unchanged.
- Accepted write: pipe_in_write & pipe_in_ready.
  - Compare pipe_in_data with the exp_state word.
  - On mismatch, increment error_count, saturating at all-ones.
  - words_in +1; exp_state advances.
- Accepted read: pipe_out_read & pipe_out_valid. Host takes pipe_out_data in that cycle; gen_state advances; words_out +1.
- A write with ready low or a read with valid low is ignored (no compare, no advance) and sets protocol_err.
- Throttle: 8-bit rotator, rotate right every cycle.
  - pipe_in_ready = rot[0] & ~restart.
  - pipe_out_valid = rot[4] & ~restart.
  - 8'hFF means never throttled; 8'h00 means permanently stalled.
- Restart coincident with write or read: restart wins, the strobe is dropped, and protocol_err is not set.
- Reset values:
  - exp_state and gen_state 32'h0000_0001; rotator 8'hFF.
  - All counters 0; protocol_err 0; first-error registers 0.
  - pipe_in_ready 1; pipe_out_valid 1; pipe_out_data = DATA_W'h1.
- Reset mid-transfer aborts immediately, to the values above.

## Timing
- pipe_out_data is a direct register output, valid in the cycle read is asserted; it shows the next word one cycle after an accepted read.
- error_count, words_in, words_out and protocol_err update on the edge ending the accepting cycle, i.e. visible next cycle.
- Back-to-back accepts at one per cycle are sustained in both directions with throttle 8'hFF.
- Restart takes effect on the next edge; the first post-restart word is accepted the cycle after restart deasserts.

## Configuration
- PIPE_PATTERN_ERRLOG_EN defined:
  - On the first mismatch after reset or restart, capture words_in (pre-increment), the expected word and the received word.
  - Later mismatches do not overwrite the capture; restart clears it.
- Not defined: the first_err_* ports remain and are driven constant 0; no capture registers are built.

## Structure
- Package pipe_pattern_pkg holds:
  - mode encodings MODE_LFSR, MODE_CNT, MODE_WALK
  - LFSR tap positions
  - DEFAULT_STATE = 32'h0000_0001
  - function seed_fixup
- One sub-module, pattern_gen: 32-bit state, load/advance/mode inputs, word output. Instantiated twice, as checker and as generator.
- Throttle rotator, counters and error capture live in the top block.

## Test plan
- Reset, mode 00, seed 0, throttle FF, restart; write 1024 words from a reference LFSR seeded 1 → error_count 0, words_in 1024, protocol_err 0.
- Mode 01, seed 32'hFFFF_FFFE, DATA_W 32; read 4 words → 32'hFFFF_FFFE, FFFF_FFFF, 0000_0000, 0000_0001 (wrap).
- Counter mode, write 100 correct words with words 10 and 57 corrupted → error_count 2, first_err_index 10, expected/received logged (macro on; zeros with macro off).
- ERR_W 4, write 20 wrong words → error_count saturates at 4'hF.
- Throttle 8'h0F: ready high 4 of every 8 cycles; a write while ready is low → ignored, protocol_err 1, words_in unchanged.
- Assert reset asynchronously mid-burst between clock edges → all outputs at reset values immediately; restart with mode 10, seed 0 → pipe_out_data sequence 1, 2, 4, 8.
